// File: rtl/round_controller.sv
// round_controller: round/match sequencer turning crash flags into winner flags, score strobe and clear.
module round_controller #(
  parameter int unsigned WIN_SCORE       = 5,
  parameter int unsigned COUNTDOWN_TICKS = 3,
  parameter int unsigned HOLD_TICKS      = 2
) (
  input  logic       clk,
  input  logic       clear_b,
  input  logic       start,
  input  logic       tick,
  input  logic       crash1,
  input  logic       crash2,
  output logic       play_en,
  output logic       round_reset,
  output logic       p1_won,
  output logic       p2_won,
  output logic       draw,
  output logic       score_strobe,
  output logic       score_clear_b,
  output logic       match_over,
  output logic [2:0] state,
  output logic [7:0] p1_rounds,
  output logic [7:0] p2_rounds
);
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COUNTDOWN  = 3'd1,
    PLAY       = 3'd2,
    ROUND_END  = 3'd3,
    MATCH_OVER = 3'd4
  } state_e;
  localparam logic [7:0] CD = 8'(COUNTDOWN_TICKS);
  localparam logic [7:0] HD = 8'(HOLD_TICKS);
  localparam logic [7:0] WS = 8'(WIN_SCORE);
  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d, p1r_q, p1r_d, p2r_q, p2r_d;
  logic       start_q, first_q, first_d;
  logic       play_en_q, play_en_d, round_reset_q, round_reset_d;
  logic       p1_won_q, p1_won_d, p2_won_q, p2_won_d, draw_q, draw_d;
  logic       strobe_q, strobe_d, clr_b_q, clr_b_d, match_q, match_d;
  logic       start_rise;
  assign start_rise = start & ~start_q;
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    p1r_d         = p1r_q;
    p2r_d         = p2r_q;
    p1_won_d      = p1_won_q;
    p2_won_d      = p2_won_q;
    draw_d        = draw_q;
    play_en_d     = play_en_q;
    match_d       = match_q;
    round_reset_d = 1'b0;
    strobe_d      = 1'b0;
    clr_b_d       = 1'b1;
    first_d       = 1'b0;
    case (state_q)
      IDLE: begin
        play_en_d = 1'b0;
        if (start_rise) begin
          state_d       = COUNTDOWN;
          round_reset_d = 1'b1;
          timer_d       = CD;
        end
      end
      COUNTDOWN: begin
        play_en_d = 1'b0;
        if (tick) begin
          if (timer_q <= 8'd1) begin
            state_d   = PLAY;
            play_en_d = 1'b1;
            timer_d   = 8'd0;
          end else timer_d = timer_q - 8'd1;
        end
      end
      PLAY: begin
        play_en_d = 1'b1;
        if (crash1 | crash2) begin
          state_d   = ROUND_END;
          play_en_d = 1'b0;
          p1_won_d  = crash2 & ~crash1;
          p2_won_d  = crash1 & ~crash2;
          draw_d    = crash1 & crash2;
          timer_d   = HD;
          first_d   = 1'b1;
        end
      end
      ROUND_END: begin
        play_en_d = 1'b0;
        // Ticks are ignored on the first cycle so the strobe cycle always happens.
        if (first_q) begin
          strobe_d = p1_won_q | p2_won_q;
          p1r_d    = (p1_won_q && p1r_q != 8'hFF) ? p1r_q + 8'd1 : p1r_q;
          p2r_d    = (p2_won_q && p2r_q != 8'hFF) ? p2r_q + 8'd1 : p2r_q;
        end else if (tick) begin
          if (timer_q <= 8'd1) begin
            timer_d = 8'd0;
            if (p1r_q >= WS || p2r_q >= WS) begin
              state_d = MATCH_OVER;
              match_d = 1'b1;
            end else begin
              state_d       = COUNTDOWN;
              round_reset_d = 1'b1;
              timer_d       = CD;
              p1_won_d      = 1'b0;
              p2_won_d      = 1'b0;
              draw_d        = 1'b0;
            end
          end else timer_d = timer_q - 8'd1;
        end
      end
      MATCH_OVER: begin
        play_en_d = 1'b0;
        match_d   = 1'b1;
        if (start_rise) begin
          state_d       = COUNTDOWN;
          clr_b_d       = 1'b0;
          p1r_d         = 8'd0;
          p2r_d         = 8'd0;
          p1_won_d      = 1'b0;
          p2_won_d      = 1'b0;
          draw_d        = 1'b0;
          match_d       = 1'b0;
          round_reset_d = 1'b1;
          timer_d       = CD;
        end
      end
      default: begin
        state_d   = IDLE;
        timer_d   = 8'd0;
        p1_won_d  = 1'b0;
        p2_won_d  = 1'b0;
        draw_d    = 1'b0;
        play_en_d = 1'b0;
        match_d   = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      state_q       <= IDLE;
      timer_q       <= 8'd0;
      p1r_q         <= 8'd0;
      p2r_q         <= 8'd0;
      start_q       <= 1'b0;
      first_q       <= 1'b0;
      play_en_q     <= 1'b0;
      round_reset_q <= 1'b0;
      p1_won_q      <= 1'b0;
      p2_won_q      <= 1'b0;
      draw_q        <= 1'b0;
      strobe_q      <= 1'b0;
      clr_b_q       <= 1'b0;
      match_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      p1r_q         <= p1r_d;
      p2r_q         <= p2r_d;
      start_q       <= start;
      first_q       <= first_d;
      play_en_q     <= play_en_d;
      round_reset_q <= round_reset_d;
      p1_won_q      <= p1_won_d;
      p2_won_q      <= p2_won_d;
      draw_q        <= draw_d;
      strobe_q      <= strobe_d;
      clr_b_q       <= clr_b_d;
      match_q       <= match_d;
    end
  end
  assign play_en       = play_en_q;
  assign round_reset   = round_reset_q;
  assign p1_won        = p1_won_q;
  assign p2_won        = p2_won_q;
  assign draw          = draw_q;
  assign score_strobe  = strobe_q;
  assign score_clear_b = clr_b_q;
  assign match_over    = match_q;
  assign state         = state_q;
  assign p1_rounds     = p1r_q;
  assign p2_rounds     = p2r_q;
endmodule

// File: doc/round_controller.md
Name: round_controller

Overview:
Round/match sequencer for the two-player light-cycle game. It sits directly upstream of the score display block. It turns raw crash flags from the game logic into a clean winner indication and a one-cycle score strobe, and it sequences countdown, play, round-end hold and match-over. It also owns the score clear line, so a new match zeroes the displayed scores.

Parameters:
WIN_SCORE, 5, rounds a player must win to end the match (1..255)
COUNTDOWN_TICKS, 3, tick pulses spent in COUNTDOWN before play starts (1..255)
HOLD_TICKS, 2, tick pulses spent in ROUND_END showing the result (1..255)

Ports:
clk  in  1  system clock
clear_b  in  1  asynchronous active-low reset
start  in  1  synchronous start button level; only its rising edge is used
tick  in  1  one-cycle frame/timebase pulse
crash1  in  1  player 1 crashed this cycle (level, valid only in PLAY)
crash2  in  1  player 2 crashed this cycle
play_en  out  1  game logic may move cycles
round_reset  out  1  one-cycle pulse that clears the playfield
p1_won  out  1  player 1 won the last round
p2_won  out  1  player 2 won the last round
draw  out  1  last round was a draw
score_strobe  out  1  one-cycle pulse; the score block counts on its rising edge
score_clear_b  out  1  active-low clear to the score block
match_over  out  1  a player reached WIN_SCORE
state  out  3  IDLE=0, COUNTDOWN=1, PLAY=2, ROUND_END=3, MATCH_OVER=4
p1_rounds  out  8  internal round count, player 1
p2_rounds  out  8  internal round count, player 2

Behaviour:
- Reset (clear_b=0, asynchronous): state=IDLE, all single-bit outputs 0, counts 0, timers 0. score_clear_b is 0 while clear_b=0 and returns to 1 on the first clk edge after release.
- start_rise = start AND NOT start_q, with start_q a register. start held high produces one event only.
- IDLE: play_en=0. On start_rise go to COUNTDOWN, pulse round_reset for 1 cycle, load timer=COUNTDOWN_TICKS.
- COUNTDOWN: crashes are ignored. The timer decrements on each tick. On the tick where timer==1, go to PLAY. play_en=1 from the first PLAY cycle.
- PLAY: crash1/crash2 are sampled every clk.
  - crash1 only: p2_won=1.
  - crash2 only: p1_won=1.
  - Both in the same cycle: draw=1, no winner.
  - On any crash, the next state is ROUND_END and play_en=0 in that same next cycle.
  - Winner/draw flags are registered and become valid on the first ROUND_END cycle.
- ROUND_END:
  - If there is a winner, score_strobe=1 on the second ROUND_END cycle only, so the flags are stable one full cycle before the strobe's rising edge. The winner's round count increments in that same cycle, saturating at 255.
  - A draw produces no strobe and no increment.
  - The timer is loaded with HOLD_TICKS on entry and decrements on tick. A tick on the first ROUND_END cycle is ignored so the strobe is never skipped.
  - When the timer expires: if p1_rounds>=WIN_SCORE or p2_rounds>=WIN_SCORE, go to MATCH_OVER. Otherwise go to COUNTDOWN with a round_reset pulse, timer=COUNTDOWN_TICKS, and p1_won/p2_won/draw cleared.
- MATCH_OVER: match_over=1, play_en=0, winner flags held.
  - On start_rise: score_clear_b=0 for exactly 1 cycle, counts zeroed, flags cleared, round_reset pulsed, then COUNTDOWN.
- start_rise outside IDLE/MATCH_OVER is ignored.
- tick and crash arriving in the same cycle in PLAY: the crash wins and the tick is irrelevant.
- Reset mid-round: the outputs above are forced immediately, with no strobe emitted.
- Unused state encodings recover to IDLE on the next clk.

Test Plan:
- Reset then start_rise, COUNTDOWN_TICKS=3 → round_reset 1 cycle; exactly 3 ticks later state=2 and play_en=1; no play_en before the 3rd tick.
- In PLAY assert crash2 for 1 cycle → next cycle state=3, play_en=0, p1_won=1; score_strobe=1 exactly one cycle after that; p1_rounds=1; after HOLD_TICKS ticks, state=1 with a round_reset pulse.
- crash1 and crash2 asserted together → draw=1, p1_won=p2_won=0, no score_strobe, counts unchanged.
- Player 2 wins 5 rounds (WIN_SCORE=5) → after the 5th hold, state=4, match_over=1, p2_rounds=5; start held high for 10 cycles → a single score_clear_b low pulse, counts 0, state=1.
- Assert clear_b low during ROUND_END before the strobe → no score_strobe, score_clear_b=0, state=0, all counts 0.
- Tick coincident with the first ROUND_END cycle, HOLD_TICKS=1 → strobe still issued once; leave ROUND_END on the next tick.
